// File: rtl/serial_capture.sv
// serial_capture: LSB-first serial-to-parallel deserializer feeding a small
// output FIFO. It keeps a sticky overflow flag and a count of accepted words.
module serial_capture #(
  parameter int WIDTH = 8,  // bits per assembled word
  parameter int DEPTH = 4   // FIFO depth in words, power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             datain,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic [15:0]      word_count
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Deserializer state
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;

  // FIFO state. Each pointer carries one extra wrap bit so that full and
  // empty can be told apart without a separate occupancy counter.
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;

  logic               overflow_q, overflow_d;
  logic [15:0]        word_count_q, word_count_d;

  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               last_bit;
  logic               complete;
  logic               push;
  logic [WIDTH-1:0]   full_word;

  // Next-state logic for the deserializer, the FIFO pointers and the status
  // flags.
  always_comb begin
    // NOTE: every signal gets a default before any branch. Without one, a
    // path that skips an assignment would infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A flush cancels any pop or sample taken on the same edge.
    pop      = !fifo_empty && word_ready && !flush;
    last_bit = en && (bit_cnt_q == CNT_W'(WIDTH - 1));
    complete = last_bit && !flush;

    // Bits above the counter are always zero in the partial word. OR-ing in
    // the incoming bit at the top therefore gives the finished word.
    full_word = shreg_q | (WIDTH'(datain) << (WIDTH - 1));

    // A full FIFO can still take the word if the head leaves on this edge.
    push = complete && (!fifo_full || pop);

    if (flush) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shreg_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (en) begin
        if (last_bit) begin
          // The counter wraps whether the word is accepted or dropped.
          state_d   = IDLE;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end else begin
          state_d            = SHIFT;
          bit_cnt_d          = bit_cnt_q + CNT_W'(1);
          shreg_d[bit_cnt_q] = datain;
        end
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      end

      if (push) begin
        wr_ptr_d     = wr_ptr_q + (PTR_W+1)'(1);
        word_count_d = word_count_q + 16'd1;
      end else if (complete) begin
        overflow_d = 1'b1;
      end
    end
  end

  // FSM and control registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // flop then samples its pre-edge inputs, regardless of statement order.
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset on purpose. The pointers define
  // which entries are valid, and word_out is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= full_word;
    end
  end

  assign word_valid = (wr_ptr_q != rd_ptr_q);
  assign word_out   = word_valid ? mem[rd_ptr_q[PTR_W-1:0]] : '0;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_serial_capture.sv
// tb_serial_capture: directed scenarios plus a random phase for
// serial_capture. Each scenario is checked against a queue-based reference
// model.
module tb_serial_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             datain;
  logic             en;
  logic             flush;
  logic             word_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             overflow;
  logic [15:0]      word_count;

  serial_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .datain     (datain),
    .en         (en),
    .flush      (flush),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the bits gathered so far for the current word, the
  // queued words, and the two status values.
  bit               m_bits[$];
  logic [WIDTH-1:0] m_fifo[$];
  logic             m_ovf;
  logic [15:0]      m_cnt;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_fifo.delete();
    m_ovf = 1'b0;
    m_cnt = 16'd0;
  endtask

  // Applies one rising edge to the model, using the inputs present at that edge.
  task automatic model_step(input bit d, input bit e, input bit r, input bit f);
    int sz;
    bit pop;
    logic [WIDTH-1:0] w;
    sz  = m_fifo.size();
    pop = (sz > 0) && r;
    if (f) begin
      m_bits.delete();
      m_fifo.delete();
      return;
    end
    if (pop) void'(m_fifo.pop_front());
    if (e) begin
      m_bits.push_back(d);
      if (m_bits.size() == WIDTH) begin
        w = '0;
        for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
        if (sz < DEPTH || pop) begin
          m_fifo.push_back(w);
          m_cnt = m_cnt + 16'd1;
        end else begin
          m_ovf = 1'b1;
        end
        m_bits.delete();
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [WIDTH-1:0] exp_out;
    exp_out = (m_fifo.size() > 0) ? m_fifo[0] : '0;
    check({tag, ".valid"},    32'(word_valid), 32'(m_fifo.size() > 0));
    check({tag, ".word_out"}, 32'(word_out),   32'(exp_out));
    check({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
    check({tag, ".count"},    32'(word_count), 32'(m_cnt));
  endtask

  // One clock: drive the inputs, take the edge, then sample 1 ns later.
  task automatic step(input bit d, input bit e, input bit r, input bit f,
                      input string tag);
    datain     = d;
    en         = e;
    word_ready = r;
    flush      = f;
    @(posedge clk);
    model_step(d, e, r, f);
    #1;
    compare_all(tag);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit r,
                           input string tag);
    for (int i = 0; i < WIDTH; i++) step(w[i], 1'b1, r, 1'b0, tag);
  endtask

  // Asynchronous reset pulse, applied away from the clock edge. All outputs
  // must be zero while reset is held.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #2;
    model_reset();
    check({tag, ".rst_valid"},    32'(word_valid), 32'd0);
    check({tag, ".rst_word_out"}, 32'(word_out),   32'd0);
    check({tag, ".rst_overflow"}, 32'(overflow),   32'd0);
    check({tag, ".rst_count"},    32'(word_count), 32'd0);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    int gap;

    rst        = 1'b0;
    datain     = 1'b0;
    en         = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    rst = 1'b1;
    #1;

    // A5 sent LSB-first with ready high. The word must be visible right after the 8th edge.
    send_word(8'hA5, 1'b1, "a5");
    check("a5.word_out", 32'(word_out), 32'hA5);
    check("a5.count",    32'(word_count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, "a5_pop");
    check("a5.drained", 32'(word_valid), 32'd0);

    // 3C sent with gaps of 0, 1 and 3 idle cycles between bits.
    do_reset("gap");
    w = 8'h3C;
    for (int i = 0; i < WIDTH; i++) begin
      step(w[i], 1'b1, 1'b0, 1'b0, "gap_bit");
      gap = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 1 : 3;
      if (i < WIDTH - 1)
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, "gap_idle");
    end
    check("gap.word_out", 32'(word_out),   32'h3C);
    check("gap.count",    32'(word_count), 32'd1);

    // Overflow: five words while the consumer stalls, then drain the FIFO.
    do_reset("ovf");
    for (int k = 1; k <= 5; k++) send_word(WIDTH'(k), 1'b0, "ovf_fill");
    check("ovf.flag",  32'(overflow),   32'd1);
    check("ovf.count", 32'(word_count), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      check("ovf.order", 32'(word_out), 32'(k));
      step(1'b0, 1'b0, 1'b1, 1'b0, "ovf_pop");
    end
    check("ovf.empty", 32'(word_valid), 32'd0);

    // FIFO is full, and a pop lands on the same edge as the last bit of EE.
    do_reset("fullpop");
    send_word(8'h11, 1'b0, "fp_fill");
    send_word(8'h22, 1'b0, "fp_fill");
    send_word(8'h33, 1'b0, "fp_fill");
    send_word(8'h44, 1'b0, "fp_fill");
    w = 8'hEE;
    for (int i = 0; i < WIDTH; i++)
      step(w[i], 1'b1, (i == WIDTH - 1), 1'b0, "fp_ee");
    check("fullpop.overflow", 32'(overflow),   32'd0);
    check("fullpop.count",    32'(word_count), 32'd5);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0, "fp_drain");
    check("fullpop.empty", 32'(word_valid), 32'd0);

    // Reset pulse after three bits. The next word must start at bit 0.
    do_reset("midrst");
    step(1'b1, 1'b1, 1'b0, 1'b0, "mr_bit");
    step(1'b1, 1'b1, 1'b0, 1'b0, "mr_bit");
    step(1'b0, 1'b1, 1'b0, 1'b0, "mr_bit");
    do_reset("midrst2");
    send_word(8'h5A, 1'b0, "mr_5a");
    check("midrst.word_out", 32'(word_out),   32'h5A);
    check("midrst.count",    32'(word_count), 32'd1);

    // Flush four bits into a word, with two words queued.
    do_reset("flush");
    send_word(8'hC3, 1'b0, "fl_fill");
    send_word(8'h7E, 1'b0, "fl_fill");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "fl_part");
    step(1'b1, 1'b1, 1'b1, 1'b1, "fl_flush");
    check("flush.valid", 32'(word_valid), 32'd0);
    check("flush.count", 32'(word_count), 32'd2);
    send_word(8'h96, 1'b0, "fl_fresh");
    check("flush.word_out", 32'(word_out),   32'h96);
    check("flush.count2",   32'(word_count), 32'd3);

    // Random traffic, with occasional flushes.
    do_reset("rand");
    for (int c = 0; c < 1500; c++)
      step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 63) == 0), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_capture.md
SERIAL_CAPTURE -- requirements
Module: serial_capture

Interface
REQ-001 Parameter WIDTH, default 8: bits per assembled word.
REQ-002 Parameter DEPTH, default 4: output FIFO depth in words; SHALL be a power of two, at least 2.
REQ-003 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 datain  input  1: serial data bit, sampled when en=1.
REQ-006 en  input  1: bit-valid qualifier for datain.
REQ-007 flush  input  1: synchronous clear of the partial word and the FIFO.
REQ-008 word_out  output  WIDTH: word at the FIFO head.
REQ-009 word_valid  output  1: high while the FIFO is non-empty.
REQ-010 word_ready  input  1: consumer accept; a pop occurs when word_valid and word_ready are both high.
REQ-011 overflow  output  1: sticky flag, set when a completed word is dropped.
REQ-012 word_count  output  16: number of words accepted into the FIFO, modulo 2^16.

Function
REQ-013 The deserializer SHALL be an FSM with two states:
- IDLE: bit counter = 0.
- SHIFT: partial word held.
- IDLE -> SHIFT on en=1 when WIDTH>1.
- SHIFT -> IDLE on the edge that samples bit WIDTH-1.
REQ-014 Bit order SHALL be LSB-first: the first sampled bit lands in word bit 0, and bit k lands in bit k.
REQ-015 When en=0, the partial word, the bit counter and the state SHALL hold unchanged; gaps of any length are legal.
REQ-016 The completed word SHALL be written to the FIFO on the same edge that samples its last bit.
- word_valid SHALL rise in the following cycle.
- Latency from the last-bit edge to word_valid is 1 cycle.
REQ-017 The bit counter SHALL wrap from WIDTH-1 to 0 whether the word is accepted or dropped.
REQ-018 If the FIFO is full and no pop occurs on the completing edge:
- The word SHALL be dropped.
- overflow SHALL be set to 1.
- word_count SHALL stay unchanged.
REQ-019 If the FIFO is full and a pop occurs on the completing edge, the new word SHALL be accepted and overflow SHALL remain unchanged.
REQ-020 Each accepted word SHALL increment word_count by 1; 16'hFFFF SHALL wrap to 16'h0000.
REQ-021 word_out SHALL stay stable while word_valid=1 and word_ready=0.
REQ-022 Words SHALL leave the FIFO in arrival order.
REQ-023 A pop with the FIFO empty SHALL have no effect.
REQ-024 flush=1 SHALL have priority over en and word_ready. On that edge it SHALL:
- Clear the partial word and the bit counter.
- Clear FIFO occupancy.
- Return the FSM to IDLE.
- Leave overflow and word_count unchanged.
- Discard any bit sampled on that edge.
REQ-025 overflow SHALL be cleared only by reset.

Reset
REQ-026 On rst=0, immediately and independent of clk, the block SHALL force:
- FSM = IDLE, bit counter = 0, partial word = 0.
- FIFO empty.
- word_valid = 0, word_out = 0, overflow = 0, word_count = 0.
REQ-027 Reset asserted mid-word SHALL discard the partial word; after rst returns to 1, the first sampled bit SHALL be bit 0 of a new word.

Verification
REQ-028 ready=1, en=1; send bits 1,0,1,0,0,1,0,1 -> word_valid=1 one cycle after the 8th edge, word_out=8'hA5, word_count=1.
REQ-029 Send 8'h3C LSB-first with en=0 gaps of 0, 1 and 3 cycles between bits -> word_out=8'h3C, word_count=1, no spurious word_valid.
REQ-030 ready=0; send words 8'h01..8'h05 -> overflow=1, word_count=4; then ready=1 -> pops 8'h01, 8'h02, 8'h03, 8'h04 in order, then word_valid=0.
REQ-031 FIFO full with 4 words, ready=1 on the same edge as the last bit of 8'hEE -> overflow=0, word_count increments by 1, and 8'hEE pops last.
REQ-032 Pulse rst low after 3 bits of a word; then send 8'h5A -> all outputs 0 during reset, then word_out=8'h5A, word_count=1.
REQ-033 flush after 4 bits with 2 words queued -> word_valid=0 next cycle, word_count unchanged; the next 8 bits form a complete fresh word.
